// File: rtl/param_phase_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_phase_ctrl_if : request/grant bus of the round-robin dwell arbiter  |
// | Revision: 1.0                                                            |
// +----------------------------------------------------------------------------+
interface param_phase_ctrl_if #(
    parameter int NCH = 4,
    parameter int CW  = 4
);
    localparam int PW = (NCH > 2) ? $clog2(NCH) : 1;

    logic           clr;
    logic           en;
    logic           hold;
    logic [NCH-1:0] req;
    logic [NCH-1:0] gnt;
    logic [PW-1:0]  phase;
    logic [CW-1:0]  cnt;
    logic           wrap;

    modport master (
        output clr, en, hold, req,
        input  gnt, phase, cnt, wrap
    );

    modport slave (
        input  clr, en, hold, req,
        output gnt, phase, cnt, wrap
    );
endinterface
`default_nettype wire

// File: rtl/param_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_phase_ctrl : round-robin arbiter with fixed-length dwell and gap    |
// | Revision: 1.0                                                            |
// +----------------------------------------------------------------------------+
module param_phase_ctrl #(
    parameter int NCH   = 4,
    parameter int CW    = 4,
    parameter int DWELL = 5
) (
    input  wire logic         ck_i,
    input  wire logic         rst_i,
    param_phase_ctrl_if.slave bus
);
    localparam int             PW       = (NCH > 2) ? $clog2(NCH) : 1;
    localparam logic [PW:0]    NCH_W    = (PW+1)'(NCH);
    localparam logic [PW-1:0]  LAST_IDX = PW'(NCH - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
    localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t         state_q;
    logic [NCH-1:0] gnt_q;
    logic [PW-1:0]  phase_q;
    logic [CW-1:0]  cnt_q;
    logic           wrap_q;
    logic [PW-1:0]  gidx_q;

    logic           sel_vld_d;
    logic [PW-1:0]  sel_idx_d;
    logic [NCH-1:0] sel_oh_d;
    logic [PW:0]    arb_sum_d;
    logic [PW-1:0]  phase_d;
    logic           dwell_end_d;

    // Scan from the highest offset down so the channel closest to phase_q wins.
    always_comb begin
        sel_vld_d = 1'b0;
        sel_idx_d = '0;
        arb_sum_d = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            arb_sum_d = {1'b0, phase_q} + (PW+1)'(i);
            if (arb_sum_d >= NCH_W) begin
                arb_sum_d = arb_sum_d - NCH_W;
            end
            if (bus.req[arb_sum_d[PW-1:0]]) begin
                sel_vld_d = 1'b1;
                sel_idx_d = arb_sum_d[PW-1:0];
            end
        end
    end

    assign sel_oh_d    = ONE_HOT0 << sel_idx_d;
    assign phase_d     = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);
    // A dropped request ends the grant even while HOLD freezes the counter.
    assign dwell_end_d = !bus.req[gidx_q] || (!bus.hold && (cnt_q == CNT_LAST));

    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            gidx_q  <= '0;
        end else if (bus.clr) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            gidx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_GAP: begin
                    wrap_q <= 1'b0;
                    cnt_q  <= '0;
                    if (bus.en && sel_vld_d) begin
                        state_q <= S_DWELL;
                        gnt_q   <= sel_oh_d;
                        gidx_q  <= sel_idx_d;
                    end else begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                    end
                end
                S_DWELL: begin
                    if (dwell_end_d) begin
                        state_q <= S_GAP;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        phase_q <= phase_d;
                        wrap_q  <= (gidx_q == LAST_IDX);
                    end else if (!bus.hold) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    cnt_q   <= '0;
                    wrap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.phase = phase_q;
    assign bus.cnt   = cnt_q;
    assign bus.wrap  = wrap_q;
endmodule
`default_nettype wire
